dwc_pcie_axi_aw_split: RTL
==========================

DWC_PCIE_AXI_AW_SPLIT -- requirements
Module: DWC_pcie_axi_aw_split

Interface
REQ-001 The block SHALL expose parameter ADDR_WD, default 64: AXI address width.
REQ-002 The block SHALL expose parameter ID_WD, default 8: AXI ID width.
REQ-003 The block SHALL expose parameter SIZE_LOG2, default 4: log2 of bytes per beat (fixed beat size).
REQ-004 The block SHALL expose parameter MAX_LOG2, default 8: log2 of split boundary in bytes; legal range SIZE_LOG2..12.
REQ-005 The block SHALL expose parameter TP, default `TP: assignment delay on all registered updates.
REQ-006 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port clrn, input, 1: synchronous active-low clear.
REQ-009 The block SHALL have port vld_from_src, input, 1: command valid from source.
REQ-010 The block SHALL have port addr_from_src, input, ADDR_WD: start address.
REQ-011 The block SHALL have port len_from_src, input, 8: AXI AWLEN, where beats = len+1.
REQ-012 The block SHALL have port id_from_src, input, ID_WD: AXI ID.
REQ-013 The block SHALL have port rdy_to_src, output, 1: ready to source.
REQ-014 The block SHALL have port vld_to_dest, output, 1: sub-burst valid.
REQ-015 The block SHALL have port addr_to_dest, output, ADDR_WD: sub-burst address.
REQ-016 The block SHALL have port len_to_dest, output, 8: sub-burst AWLEN.
REQ-017 The block SHALL have port id_to_dest, output, ID_WD: ID copied from the command.
REQ-018 The block SHALL have port last_to_dest, output, 1: marks the final sub-burst of a command.
REQ-019 The block SHALL have port rdy_from_dest, input, 1: ready from the downstream register slice.

Function
REQ-020 The block SHALL split each incrementing AW command into sub-bursts that do not cross any 2^MAX_LOG2-byte address boundary, and SHALL feed them to the downstream register slice.
REQ-021 The block SHALL use a two-state FSM with states IDLE and BUSY.
REQ-022 In IDLE, the block SHALL drive vld_to_dest=0 and rdy_to_src=1.
REQ-023 In BUSY, the block SHALL drive vld_to_dest=1, and the outputs SHALL be derived from the registers cur_addr, rem_beats (9 bits, range 1..256) and id.
REQ-024 On accept (vld_from_src & rdy_to_src), the block SHALL load cur_addr=addr_from_src, rem_beats=len_from_src+1 and id=id_from_src, and SHALL enter BUSY; the first sub-burst SHALL be valid on the next cycle (latency 1).
REQ-025 The block SHALL compute bnd_beats = (2^MAX_LOG2 - cur_addr[MAX_LOG2-1:0]) >> SIZE_LOG2, with range 1..2^(MAX_LOG2-SIZE_LOG2).
REQ-026 The block SHALL compute sub_beats = min(rem_beats, bnd_beats), and SHALL drive len_to_dest=sub_beats-1, addr_to_dest=cur_addr, last_to_dest=(rem_beats==bnd_beats) or (rem_beats<bnd_beats).
REQ-027 On a downstream handshake (vld_to_dest & rdy_from_dest) with last_to_dest=0, the block SHALL update cur_addr += sub_beats<<SIZE_LOG2 (modulo 2^ADDR_WD, so wrap at the top of address space is silent) and rem_beats -= sub_beats, and SHALL stay in BUSY.
REQ-028 On a downstream handshake with last_to_dest=1, the block SHALL return to IDLE unless a new command is accepted in the same cycle.
REQ-029 rdy_to_src SHALL equal IDLE | (BUSY & last_to_dest & rdy_from_dest), giving back-to-back commands with no bubble; a new command accepted in that cycle SHALL load the registers and remain in BUSY.
REQ-030 With rdy_from_dest=0, all dest outputs SHALL hold stable and no register SHALL change.
REQ-031 The block SHALL assume only INCR bursts and addresses aligned to the beat size.
REQ-032 The block SHALL pass unaligned low address bits (below SIZE_LOG2) unchanged on the first sub-burst only; subsequent sub-bursts SHALL be boundary-aligned.
REQ-033 A sub-burst SHALL never exceed 256 beats.

Reset
REQ-034 While rstn=0, the block SHALL asynchronously reset to state IDLE with cur_addr, rem_beats and id = 0; outputs SHALL then be vld_to_dest=0, rdy_to_src=1, addr/len/id/last_to_dest=0.
REQ-035 When clrn=0 at a clock edge, the block SHALL apply the same values synchronously, with priority over any handshake.
REQ-036 A mid-split reset or clear SHALL abandon the remaining sub-bursts.

Verification (SIZE_LOG2=4, MAX_LOG2=8)
REQ-037 addr 0x1000 len 7 -> one sub-burst: addr 0x1000, len 7, last=1, valid one cycle after accept.
REQ-038 addr 0x10F0 len 3 -> (0x10F0, len 0, last 0), then (0x1100, len 2, last 1).
REQ-039 addr 0x0 len 255 -> 16 sub-bursts of len 15 at 0x000, 0x100 ... 0xF00, with last=1 only on the 16th.
REQ-040 rdy_from_dest=0 for 5 cycles mid-split -> addr, len, id, last and valid are unchanged every cycle, and no sub-burst is lost or duplicated.
REQ-041 Second command held valid during the last handshake of the first -> it is accepted that cycle, and its first sub-burst appears the next cycle with no idle gap.
REQ-042 clrn=0 for one cycle during the 2nd of 16 sub-bursts -> next cycle vld_to_dest=0 and rdy_to_src=1, and the remaining sub-bursts are not issued.

Source files
------------

// File: rtl/dwc_pcie_axi_aw_split.sv
// dwc_pcie_axi_aw_split: splits INCR AW commands into sub-bursts that never cross a 2^MAX_LOG2-byte boundary
`ifndef TP
`define TP 0
`endif
module dwc_pcie_axi_aw_split #(
    parameter int ADDR_WD   = 64,
    parameter int ID_WD     = 8,
    parameter int SIZE_LOG2 = 4,
    parameter int MAX_LOG2  = 8,
    parameter int TP        = `TP
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clrn,
    input  logic               vld_from_src,
    input  logic [ADDR_WD-1:0] addr_from_src,
    input  logic [7:0]         len_from_src,
    input  logic [ID_WD-1:0]   id_from_src,
    output logic               rdy_to_src,
    output logic               vld_to_dest,
    output logic [ADDR_WD-1:0] addr_to_dest,
    output logic [7:0]         len_to_dest,
    output logic [ID_WD-1:0]   id_to_dest,
    output logic               last_to_dest,
    input  logic               rdy_from_dest
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [ADDR_WD-1:0] LOW_MASK = ADDR_WD'((64'd1 << SIZE_LOG2) - 64'd1);

    // out-of-range parameters instantiate a module that does not exist, failing elaboration
    if (MAX_LOG2 < SIZE_LOG2 || MAX_LOG2 > 12 || TP < 0) begin : g_illegal_params
        illegal_parameter_setting u_err ();
    end

    logic [0:0]         r_state;
    logic [ADDR_WD-1:0] r_addr;
    logic [8:0]         r_rem;
    logic [ID_WD-1:0]   r_id;
    logic               w_busy;
    logic [12:0]        w_bnd;
    logic               w_fits;
    logic [8:0]         w_sub;
    logic               w_acc;
    logic               w_hs;

    // beats to the boundary are measured from the beat-aligned address so an unaligned start cannot yield zero
    assign w_busy       = r_state == BUSY;
    assign w_bnd        = 13'(2 ** (MAX_LOG2 - SIZE_LOG2)) - (13'(r_addr[MAX_LOG2-1:0]) >> SIZE_LOG2);
    assign w_fits       = {4'b0, r_rem} <= w_bnd;
    assign w_sub        = w_fits ? r_rem : w_bnd[8:0];
    assign vld_to_dest  = w_busy;
    assign last_to_dest = w_busy & w_fits;
    assign addr_to_dest = w_busy ? r_addr : '0;
    assign len_to_dest  = w_busy ? w_sub[7:0] - 8'd1 : 8'd0;
    assign id_to_dest   = w_busy ? r_id : '0;
    assign rdy_to_src   = ~w_busy | (last_to_dest & rdy_from_dest);
    assign w_acc        = vld_from_src & rdy_to_src;
    assign w_hs         = w_busy & rdy_from_dest;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_id    <= '0;
        end else if (!clrn) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_id    <= '0;
        end else if (w_acc) begin
            r_state <= BUSY;
            r_addr  <= addr_from_src;
            r_rem   <= {1'b0, len_from_src} + 9'd1;
            r_id    <= id_from_src;
        end else if (w_hs) begin
            if (last_to_dest) begin
                r_state <= IDLE;
            end else begin
                r_addr <= (r_addr & ~LOW_MASK) + (ADDR_WD'(w_sub) << SIZE_LOG2);
                r_rem  <= r_rem - w_sub;
            end
        end
    end
endmodule
